// File: rtl/jtsdram_bank_arb.sv
// Round-robin arbiter sharing one SDRAM command port among four bank engines,
// with internally scheduled auto-refresh. Optional stats: JTSDRAM_ARB_STATS_EN.
module jtsdram_bank_arb #(
  parameter int AW         = 22,
  parameter int REF_PERIOD = 780
) (
  input  logic            rst,
  input  logic            clk,
  input  logic [3:0]      ba_req,
  input  logic [4*AW-1:0] ba_addr,
  input  logic [3:0]      ba_wr,
  output logic [3:0]      ba_ack,
  output logic [3:0]      ba_rdy,
  output logic            cmd_valid,
  output logic [1:0]      cmd_ba,
  output logic [AW-1:0]   cmd_addr,
  output logic            cmd_wr,
  input  logic            cmd_ready,
  input  logic            cmd_done,
  output logic            ref_req,
  input  logic            ref_ack
`ifdef JTSDRAM_ARB_STATS_EN
  ,
  output logic [4*16-1:0] grant_cnt,
  output logic            ref_late
`endif
);

  localparam int CW = $clog2(REF_PERIOD);
  localparam logic [CW-1:0] CNT_TOP = CW'(REF_PERIOD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_REF   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    last_ba_q, last_ba_d;
  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          ref_rearm_q, ref_rearm_d;
  logic          ref_req_q, ref_req_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [1:0]    cmd_ba_q, cmd_ba_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [3:0]    ba_ack_q, ba_ack_d;
  logic [3:0]    ba_rdy_q, ba_rdy_d;

  logic          ref_exp;
  logic [2:0]    rot_sh;
  logic [3:0]    rot;
  logic [1:0]    pick_off;
  logic [1:0]    pick_ba;

  // Rotate requests so bit 0 is the bank right after the last winner.
  always_comb begin
    rot_sh   = {1'b0, last_ba_q} + 3'd1;
    rot      = 4'({ba_req, ba_req} >> rot_sh);
    pick_off = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (rot[i]) pick_off = 2'(i);
    pick_ba  = last_ba_q + 2'd1 + pick_off;
  end

  always_comb begin
    state_d     = state_q;
    last_ba_d   = last_ba_q;
    ref_req_d   = ref_req_q;
    cmd_valid_d = cmd_valid_q;
    cmd_ba_d    = cmd_ba_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wr_d    = cmd_wr_q;
    ba_ack_d    = 4'd0;
    ba_rdy_d    = 4'd0;
    ref_exp     = (ref_cnt_q == '0);
    ref_cnt_d   = ref_exp ? CNT_TOP : ref_cnt_q - CW'(1);
    ref_pend_d  = ref_pend_q;
    ref_rearm_d = ref_rearm_q;

    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d   = S_REF;
          ref_req_d = 1'b1;
        end else if (|ba_req) begin
          state_d     = S_GRANT;
          last_ba_d   = pick_ba;
          cmd_valid_d = 1'b1;
          cmd_ba_d    = pick_ba;
          cmd_addr_d  = ba_addr[int'(pick_ba)*AW +: AW];
          cmd_wr_d    = ba_wr[pick_ba];
        end
      end
      S_GRANT: begin
        if (cmd_ready) begin
          cmd_valid_d        = 1'b0;
          ba_ack_d[cmd_ba_q] = 1'b1;
          if (cmd_done) begin
            ba_rdy_d[cmd_ba_q] = 1'b1;
            state_d            = S_IDLE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cmd_done) begin
          ba_rdy_d[cmd_ba_q] = 1'b1;
          state_d            = S_IDLE;
        end
      end
      default: begin
        // An expiry seen while refreshing earns one more refresh afterwards.
        if (ref_exp) ref_rearm_d = 1'b1;
        if (ref_ack) begin
          ref_req_d   = 1'b0;
          ref_pend_d  = ref_rearm_q;
          ref_rearm_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    if (ref_exp) ref_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_ba_q   <= 2'd3;
      ref_cnt_q   <= CNT_TOP;
      ref_pend_q  <= 1'b0;
      ref_rearm_q <= 1'b0;
      ref_req_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_ba_q    <= 2'd0;
      cmd_addr_q  <= '0;
      cmd_wr_q    <= 1'b0;
      ba_ack_q    <= 4'd0;
      ba_rdy_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_ba_q   <= last_ba_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      ref_rearm_q <= ref_rearm_d;
      ref_req_q   <= ref_req_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wr_q    <= cmd_wr_d;
      ba_ack_q    <= ba_ack_d;
      ba_rdy_q    <= ba_rdy_d;
    end
  end

  assign ba_ack    = ba_ack_q;
  assign ba_rdy    = ba_rdy_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wr    = cmd_wr_q;
  assign ref_req   = ref_req_q;

`ifdef JTSDRAM_ARB_STATS_EN
  logic [3:0][15:0] gcnt_q;
  logic             ref_late_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q     <= '0;
      ref_late_q <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ba_ack_d[b] && gcnt_q[b] != 16'hFFFF) gcnt_q[b] <= gcnt_q[b] + 16'd1;
      if (ref_exp && ref_pend_q) ref_late_q <= 1'b1;
    end
  end

  assign grant_cnt = gcnt_q;
  assign ref_late  = ref_late_q;
`endif

endmodule
